// File: rtl/factor_quiz_ctrl.sv
// factor_quiz_ctrl
// Round sequencer for the factorization quiz. For every round it requests a
// problem word, latches the 12-bit problem and its 24-bit expected factor
// list, shows the problem, waits for a submit press or a timeout, then judges
// the player's answer. It keeps score and round count and drives the 24-bit
// display word used by the 7-seg/LED output stage.
//
// Parameters:
//   ROUNDS      rounds per game (1..15)
//   TIME_LIMIT  tick pulses allowed per round before timeout (1..255)
//   DB_CYCLES   consecutive high samples needed to accept a key press (2..15)
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-low reset
//   num_array  in   [35:24] problem, [23:0] expected answer (six 4-bit factors)
//   key        in   raw buttons, [0]=start/next, [1]=submit
//   ans        in   player's entered factors, packed like num_array[23:0]
//   tick       in   one-cycle timebase strobe
//   prob_req   out  one-cycle request for the next problem word
//   disp       out  display word
//   judge_ok   out  last round answered correctly (held while showing result)
//   judge_ng   out  last round wrong or timed out (held while showing result)
//   score      out  correct rounds this game
//   round      out  current round index, 0-based
//   busy       out  high whenever a game is in progress
//   done       out  game finished

module factor_quiz_ctrl #(
  parameter int ROUNDS     = 8,
  parameter int TIME_LIMIT = 30,
  parameter int DB_CYCLES  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [35:0] num_array,
  input  logic [1:0]  key,
  input  logic [23:0] ans,
  input  logic        tick,
  output logic        prob_req,
  output logic [23:0] disp,
  output logic        judge_ok,
  output logic        judge_ng,
  output logic [3:0]  score,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] DB_MAX     = 4'(DB_CYCLES);
  localparam logic [3:0] DB_FIRE    = 4'(DB_CYCLES - 1);
  localparam logic [7:0] TIMER_INIT = 8'(TIME_LIMIT);
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_ASK,
    S_JUDGE,
    S_RESULT,
    S_DONE
  } state_t;

  state_t      state, state_next;
  logic [1:0]  sync_a, sync_b;
  logic [1:0]  press;
  logic        start_ev, submit_ev;
  logic [11:0] prob, prob_next;
  logic [23:0] exp_ans, exp_next;
  logic [7:0]  timer, timer_next;
  logic [3:0]  score_next, round_next;
  logic        ok_next, ng_next;

  // Two-flop synchroniser for the raw buttons.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_a <= 2'b00;
      sync_b <= 2'b00;
    end else begin
      sync_a <= key;
      sync_b <= sync_a;
    end
  end

  // Per-key debounce: the counter restarts whenever the synced level drops,
  // and saturates at DB_MAX so a held key fires exactly once.
  for (genvar i = 0; i < 2; i++) begin : g_debounce
    logic [3:0] cnt;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        cnt <= 4'd0;
      end else if (!sync_b[i]) begin
        cnt <= 4'd0;
      end else if (cnt != DB_MAX) begin
        cnt <= cnt + 4'd1;
      end
    end

    // Fires on the DB_CYCLES-th consecutive high sample.
    assign press[i] = sync_b[i] && (cnt == DB_FIRE);
  end

  // Submit has priority: a simultaneous start is dropped.
  assign submit_ev = press[1];
  assign start_ev  = press[0] & ~press[1];

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      prob     <= 12'h000;
      exp_ans  <= 24'h000000;
      timer    <= 8'd0;
      score    <= 4'd0;
      round    <= 4'd0;
      judge_ok <= 1'b0;
      judge_ng <= 1'b0;
    end else begin
      state    <= state_next;
      prob     <= prob_next;
      exp_ans  <= exp_next;
      timer    <= timer_next;
      score    <= score_next;
      round    <= round_next;
      judge_ok <= ok_next;
      judge_ng <= ng_next;
    end
  end

  // Next-state and output logic. Everything holds by default; each state
  // only overrides what it changes.
  always_comb begin
    state_next = state;
    prob_next  = prob;
    exp_next   = exp_ans;
    timer_next = timer;
    score_next = score;
    round_next = round;
    ok_next    = judge_ok;
    ng_next    = judge_ng;
    prob_req   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    disp       = 24'h000000;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_ev) begin
          state_next = S_LOAD;
          round_next = 4'd0;
          score_next = 4'd0;
        end
      end

      S_LOAD: begin
        prob_req   = 1'b1;
        state_next = S_FETCH;
      end

      // The source answers prob_req one cycle later, which is this state.
      S_FETCH: begin
        prob_next  = num_array[35:24];
        exp_next   = num_array[23:0];
        timer_next = TIMER_INIT;
        state_next = S_ASK;
      end

      // A submit in the same cycle as the last tick beats the timeout
      // because it is tested first.
      S_ASK: begin
        disp = {12'h000, prob};
        if (submit_ev) begin
          state_next = S_JUDGE;
        end else if (tick) begin
          if (timer <= 8'd1) begin
            timer_next = 8'd0;
            ng_next    = 1'b1;
            state_next = S_RESULT;
          end else begin
            timer_next = timer - 8'd1;
          end
        end
      end

      S_JUDGE: begin
        if (ans == exp_ans) begin
          ok_next    = 1'b1;
          score_next = (score == 4'd15) ? 4'd15 : score + 4'd1;
        end else begin
          ng_next = 1'b1;
        end
        state_next = S_RESULT;
      end

      S_RESULT: begin
        disp = exp_ans;
        if (start_ev) begin
          ok_next = 1'b0;
          ng_next = 1'b0;
          if (round == LAST_ROUND) begin
            state_next = S_DONE;
          end else begin
            round_next = round + 4'd1;
            state_next = S_LOAD;
          end
        end
      end

      // Score and round stay visible until the next game starts.
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        disp = {20'h00000, score};
        if (start_ev) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
